// File: rtl/sha2_pkg.sv
// sha2_pkg: shared types, constants and bit functions for the SHA-256/SHA-224 engine.
//   word_t        32-bit datapath word
//   sha2_mode_e   ModeSha256 / ModeSha224
//   sha2_state_t  working variables a..h (a in the MSBs)
//   K, IV256, IV224 constant tables; ch, maj, Sigma0/1, sigma0/1 helpers; iv_word selector
package sha2_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        ModeSha256 = 1'b0,
        ModeSha224 = 1'b1
    } sha2_mode_e;

    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } sha2_state_t;

    localparam int unsigned NumRounds = 64;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic word_t rotr(word_t x, int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(word_t x, word_t y, word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(word_t x, word_t y, word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t Sigma0(word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t Sigma1(word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t sigma0(word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t iv_word(sha2_mode_e mode, logic [2:0] idx);
        return (mode == ModeSha224) ? IV224[idx] : IV256[idx];
    endfunction

endpackage

// File: rtl/sha2_round.sv
// sha2_round: one combinational SHA-2 compression round.
//   i_state  working variables a..h before the round
//   i_k      round constant K[t]
//   i_w      schedule word W[t]
//   o_state  working variables after the round
module sha2_round
    import sha2_pkg::*;
(
    input  sha2_state_t i_state,
    input  word_t       i_k,
    input  word_t       i_w,
    output sha2_state_t o_state
);

    word_t w_t1;
    word_t w_t2;

    assign w_t1 = i_state.h + Sigma1(i_state.e) + ch(i_state.e, i_state.f, i_state.g) + i_k + i_w;
    assign w_t2 = Sigma0(i_state.a) + maj(i_state.a, i_state.b, i_state.c);

    always_comb begin
        o_state.a = w_t1 + w_t2;
        o_state.b = i_state.a;
        o_state.c = i_state.b;
        o_state.d = i_state.c;
        o_state.e = i_state.d + w_t1;
        o_state.f = i_state.e;
        o_state.g = i_state.f;
        o_state.h = i_state.g;
    end

endmodule

// File: rtl/sha2_core.sv
// sha2_core: iterative SHA-256/SHA-224 compression engine, one pre-padded block per start,
// chaining state kept across blocks.
//   clk_i, rst_ni     clock, synchronous active-low reset
//   block_i           512-bit padded block, W[0] in the MSBs, sampled on acceptance
//   enable_hash_i     start a block (only honoured while idle)
//   rst_hash_i        reload IV for mode_i, abort any running block
//   mode_i            0 = SHA-256, 1 = SHA-224 (sampled with rst_hash_i)
//   hold_o, idle_o    busy / ready status
//   digest_o          chaining state H0..H7 ({H0..H6, 0} in SHA-224 mode)
//   digest_valid_o    digest_o holds the result of the last completed block
// Build option: define SHA2_224_EN to honour mode_i; otherwise the core is SHA-256 only.
module sha2_core
    import sha2_pkg::*;
#(
    parameter int unsigned BlockWidth     = 512,
    parameter int unsigned DigestWidth    = 256,
    parameter int unsigned RoundsPerCycle = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [BlockWidth-1:0]  block_i,
    input  logic                   enable_hash_i,
    input  logic                   rst_hash_i,
    input  logic                   mode_i,
    output logic                   hold_o,
    output logic                   idle_o,
    output logic [DigestWidth-1:0] digest_o,
    output logic                   digest_valid_o
);

    if (BlockWidth != 512) begin : g_bad_block
        $error("sha2_core: BlockWidth must be 512");
    end
    if (DigestWidth != 256) begin : g_bad_digest
        $error("sha2_core: DigestWidth must be 256");
    end
    if (RoundsPerCycle != 1 && RoundsPerCycle != 2 && RoundsPerCycle != 4) begin : g_bad_rpc
        $error("sha2_core: RoundsPerCycle must be 1, 2 or 4");
    end

    localparam int         Rpc      = int'(RoundsPerCycle);
    localparam logic [6:0] CntStep  = 7'(RoundsPerCycle);
    localparam logic [6:0] CntLast  = 7'(NumRounds);

    typedef enum logic [1:0] {StIdle, StRounds, StFinal} state_e;

    state_e      r_state;
    sha2_mode_e  r_mode;
    logic        r_valid;
    logic [6:0]  r_cnt;
    sha2_state_t r_work;
    word_t       r_h [8];
    word_t       r_w [16];
    word_t       w_w_next [16];
    sha2_mode_e  w_mode_sel;

`ifdef SHA2_224_EN
    assign w_mode_sel = sha2_mode_e'(mode_i);
`else
    logic w_unused_mode;
    assign w_unused_mode = mode_i;
    assign w_mode_sel    = ModeSha256;
`endif

    // Round chain: stage g consumes W[t+g] (window slot g) and K[t+g].
    for (genvar g = 0; g < Rpc; g++) begin : g_round
        sha2_state_t w_in;
        sha2_state_t w_out;
        logic [5:0]  w_kidx;
        if (g == 0) begin : g_first
            assign w_in = r_work;
        end else begin : g_next
            assign w_in = g_round[g-1].w_out;
        end
        assign w_kidx = r_cnt[5:0] + 6'(g);
        sha2_round u_round (
            .i_state (w_in),
            .i_k     (K[w_kidx]),
            .i_w     (r_w[g]),
            .o_state (w_out)
        );
    end

    // Extend the schedule by Rpc words; later words may depend on ones produced this cycle.
    always_comb begin
        word_t ext [16+Rpc];
        for (int i = 0; i < 16; i++) ext[i] = r_w[i];
        for (int j = 0; j < Rpc; j++) begin
            ext[16+j] = sigma1(ext[14+j]) + ext[9+j] + sigma0(ext[1+j]) + ext[j];
        end
        for (int i = 0; i < 16; i++) w_w_next[i] = ext[i+Rpc];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_mode  <= ModeSha256;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_work  <= '0;
            for (int i = 0; i < 8; i++) r_h[i] <= IV256[i];
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
        end else if (rst_hash_i) begin
            r_state <= StIdle;
            r_mode  <= w_mode_sel;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            for (int i = 0; i < 8; i++) r_h[i] <= iv_word(w_mode_sel, 3'(i));
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (enable_hash_i) begin
                        for (int i = 0; i < 16; i++) r_w[i] <= block_i[BlockWidth-1-32*i -: 32];
                        r_work  <= {r_h[0], r_h[1], r_h[2], r_h[3],
                                    r_h[4], r_h[5], r_h[6], r_h[7]};
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_state <= StRounds;
                    end
                end
                StRounds: begin
                    // Counter hits 64 after the last round; that cycle only moves to FINAL.
                    if (r_cnt == CntLast) begin
                        r_state <= StFinal;
                    end else begin
                        r_work <= g_round[Rpc-1].w_out;
                        r_w    <= w_w_next;
                        r_cnt  <= r_cnt + CntStep;
                    end
                end
                StFinal: begin
                    r_h[0]  <= r_h[0] + r_work.a;
                    r_h[1]  <= r_h[1] + r_work.b;
                    r_h[2]  <= r_h[2] + r_work.c;
                    r_h[3]  <= r_h[3] + r_work.d;
                    r_h[4]  <= r_h[4] + r_work.e;
                    r_h[5]  <= r_h[5] + r_work.f;
                    r_h[6]  <= r_h[6] + r_work.g;
                    r_h[7]  <= r_h[7] + r_work.h;
                    r_valid <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign hold_o         = (r_state != StIdle);
    assign idle_o         = (r_state == StIdle);
    assign digest_valid_o = r_valid;
    assign digest_o       = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6],
                             (r_mode == ModeSha224) ? 32'h0 : r_h[7]};

endmodule

// File: tb/tb_sha2_core.sv
// tb_sha2_core: scoreboard bench for sha2_core, running R=1, R=2 and R=4 instances in parallel
// from the same stimulus. Expected digests are queued when a block is launched and popped when
// the R=1 instance (the slowest) reports completion.
module tb_sha2_core;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO1_BLK  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO2_BLK  = {480'h0, 32'h000001c0};

    localparam logic [255:0] IV256_D  =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC256   =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] ABC224   =
        256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    localparam logic [255:0] TWO256   =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] EMPTY256 =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [511:0] blk = '0;
    logic         en = 1'b0;
    logic         rh = 1'b0;
    logic         mode = 1'b0;
    logic         hold1, idle1, val1, hold2, idle2, val2, hold4, idle4, val4;
    logic [255:0] dig1, dig2, dig4;

    int n_checks = 0;
    int n_errors = 0;
    logic [255:0] sb_q [$];

    always #5 clk = ~clk;

    sha2_core #(.RoundsPerCycle(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .block_i(blk), .enable_hash_i(en), .rst_hash_i(rh),
        .mode_i(mode), .hold_o(hold1), .idle_o(idle1), .digest_o(dig1), .digest_valid_o(val1)
    );
    sha2_core #(.RoundsPerCycle(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .block_i(blk), .enable_hash_i(en), .rst_hash_i(rh),
        .mode_i(mode), .hold_o(hold2), .idle_o(idle2), .digest_o(dig2), .digest_valid_o(val2)
    );
    sha2_core #(.RoundsPerCycle(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .block_i(blk), .enable_hash_i(en), .rst_hash_i(rh),
        .mode_i(mode), .hold_o(hold4), .idle_o(idle4), .digest_o(dig4), .digest_valid_o(val4)
    );

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_rst_hash(input logic m);
        mode = m;
        rh   = 1'b1;
        @(posedge clk); #1;
        rh   = 1'b0;
    endtask

    // Acceptance edge is "edge 0".
    task automatic start_block(input logic [511:0] b);
        blk = b;
        en  = 1'b1;
        @(posedge clk); #1;
        en  = 1'b0;
    endtask

    // Edges after acceptance at which each instance's valid was first seen (-1 = never).
    task automatic wait_done(input int pulse_at, input bit scramble,
                             output int l1, output int l2, output int l4);
        l1 = -1; l2 = -1; l4 = -1;
        for (int n = 1; n <= 150 && l1 < 0; n++) begin
            @(posedge clk); #1;
            if (val1 && l1 < 0) l1 = n;
            if (val2 && l2 < 0) l2 = n;
            if (val4 && l4 < 0) l4 = n;
            en = (n == pulse_at);
            if (n == pulse_at) blk = ABC_BLK;
            else if (scramble) blk = rand_block();
        end
        en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++; if (idle1 !== 1'b1) begin n_errors++; $display("FAIL reset_idle: got %b want 1", idle1); end
        n_checks++; if (hold1 !== 1'b0) begin n_errors++; $display("FAIL reset_hold: got %b want 0", hold1); end
        n_checks++; if (val1 !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", val1); end
        n_checks++; if (dig1 !== IV256_D) begin n_errors++; $display("FAIL reset_digest: got %h want %h", dig1, IV256_D); end
    endtask

    task automatic test_abc();
        int l1, l2, l4;
        logic [255:0] exp;
        do_rst_hash(1'b0);
        sb_q.push_back(ABC256);
        start_block(ABC_BLK);
        n_checks++; if (hold1 !== 1'b1 || idle1 !== 1'b0) begin n_errors++; $display("FAIL abc_busy: got hold=%b idle=%b want 1/0", hold1, idle1); end
        n_checks++; if (val1 !== 1'b0) begin n_errors++; $display("FAIL abc_valid_clr: got %b want 0", val1); end
        wait_done(0, 1'b0, l1, l2, l4);
        exp = sb_q.pop_front();
        n_checks++; if (dig1 !== exp) begin n_errors++; $display("FAIL abc_r1: got %h want %h", dig1, exp); end
        n_checks++; if (dig2 !== exp) begin n_errors++; $display("FAIL abc_r2: got %h want %h", dig2, exp); end
        n_checks++; if (dig4 !== exp) begin n_errors++; $display("FAIL abc_r4: got %h want %h", dig4, exp); end
        n_checks++; if (l1 !== 66) begin n_errors++; $display("FAIL abc_lat_r1: got %0d want 66", l1); end
        n_checks++; if (l2 !== 34) begin n_errors++; $display("FAIL abc_lat_r2: got %0d want 34", l2); end
        n_checks++; if (l4 !== 18) begin n_errors++; $display("FAIL abc_lat_r4: got %0d want 18", l4); end
        n_checks++; if (idle1 !== 1'b1 || hold1 !== 1'b0) begin n_errors++; $display("FAIL abc_idle: got idle=%b hold=%b want 1/0", idle1, hold1); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (val1 !== 1'b1) begin n_errors++; $display("FAIL abc_valid_hold: got %b want 1", val1); end
        n_checks++; if (dig1 !== exp) begin n_errors++; $display("FAIL abc_digest_hold: got %h want %h", dig1, exp); end
    endtask

    task automatic test_two_block();
        int l1, l2, l4;
        logic [255:0] exp;
        do_rst_hash(1'b0);
        start_block(TWO1_BLK);
        wait_done(0, 1'b0, l1, l2, l4);
        n_checks++; if (l1 !== 66) begin n_errors++; $display("FAIL two_lat_blk1: got %0d want 66", l1); end
        sb_q.push_back(TWO256);
        start_block(TWO2_BLK);
        wait_done(0, 1'b0, l1, l2, l4);
        exp = sb_q.pop_front();
        n_checks++; if (dig1 !== exp) begin n_errors++; $display("FAIL two_r1: got %h want %h", dig1, exp); end
        n_checks++; if (dig2 !== exp) begin n_errors++; $display("FAIL two_r2: got %h want %h", dig2, exp); end
        n_checks++; if (dig4 !== exp) begin n_errors++; $display("FAIL two_r4: got %h want %h", dig4, exp); end
        n_checks++; if (l2 !== 34) begin n_errors++; $display("FAIL two_lat_r2: got %0d want 34", l2); end
        n_checks++; if (l4 !== 18) begin n_errors++; $display("FAIL two_lat_r4: got %0d want 18", l4); end
    endtask

    task automatic test_sha224();
        int l1, l2, l4;
        logic [255:0] exp;
        do_rst_hash(1'b1);
`ifdef SHA2_224_EN
        sb_q.push_back(ABC224);
`else
        sb_q.push_back(ABC256);
`endif
        start_block(ABC_BLK);
        wait_done(0, 1'b0, l1, l2, l4);
        exp = sb_q.pop_front();
        n_checks++; if (dig1 !== exp) begin n_errors++; $display("FAIL s224_r1: got %h want %h", dig1, exp); end
        n_checks++; if (dig2 !== exp) begin n_errors++; $display("FAIL s224_r2: got %h want %h", dig2, exp); end
        n_checks++; if (dig4 !== exp) begin n_errors++; $display("FAIL s224_r4: got %h want %h", dig4, exp); end
    endtask

    task automatic test_empty_enable_pulse();
        int l1, l2, l4;
        logic [255:0] exp;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.push_back(EMPTY256);
        start_block(EMPTY_BLK);
        wait_done(10, 1'b0, l1, l2, l4);
        exp = sb_q.pop_front();
        n_checks++; if (dig1 !== exp) begin n_errors++; $display("FAIL empty_r1: got %h want %h", dig1, exp); end
        n_checks++; if (dig2 !== exp) begin n_errors++; $display("FAIL empty_r2: got %h want %h", dig2, exp); end
        n_checks++; if (dig4 !== exp) begin n_errors++; $display("FAIL empty_r4: got %h want %h", dig4, exp); end
        n_checks++; if (l1 !== 66) begin n_errors++; $display("FAIL empty_lat_r1: got %0d want 66", l1); end
        n_checks++; if (l4 !== 18) begin n_errors++; $display("FAIL empty_lat_r4: got %0d want 18", l4); end
    endtask

    task automatic test_block_stable();
        int l1, l2, l4;
        logic [255:0] exp;
        do_rst_hash(1'b0);
        sb_q.push_back(ABC256);
        start_block(ABC_BLK);
        wait_done(0, 1'b1, l1, l2, l4);
        exp = sb_q.pop_front();
        n_checks++; if (dig1 !== exp) begin n_errors++; $display("FAIL stable_r1: got %h want %h", dig1, exp); end
        n_checks++; if (dig2 !== exp) begin n_errors++; $display("FAIL stable_r2: got %h want %h", dig2, exp); end
        n_checks++; if (dig4 !== exp) begin n_errors++; $display("FAIL stable_r4: got %h want %h", dig4, exp); end
    endtask

    task automatic test_abort();
        do_rst_hash(1'b0);
        start_block(ABC_BLK);
        repeat (30) @(posedge clk);
        #1;
        rh = 1'b1;
        @(posedge clk); #1;
        rh = 1'b0;
        n_checks++; if (idle1 !== 1'b1 || hold1 !== 1'b0) begin n_errors++; $display("FAIL abort_state: got idle=%b hold=%b want 1/0", idle1, hold1); end
        n_checks++; if (val1 !== 1'b0) begin n_errors++; $display("FAIL abort_valid: got %b want 0", val1); end
        n_checks++; if (dig1 !== IV256_D) begin n_errors++; $display("FAIL abort_digest: got %h want %h", dig1, IV256_D); end
        n_checks++; if (val4 !== 1'b0) begin n_errors++; $display("FAIL abort_valid_r4: got %b want 0", val4); end
        n_checks++; if (idle2 !== 1'b1 || hold2 !== 1'b0) begin n_errors++; $display("FAIL abort_state_r2: got idle=%b hold=%b want 1/0", idle2, hold2); end

        // rst_hash_i and enable_hash_i together: enable is dropped
        blk = ABC_BLK;
        rh  = 1'b1;
        en  = 1'b1;
        @(posedge clk); #1;
        rh  = 1'b0;
        en  = 1'b0;
        n_checks++; if (idle1 !== 1'b1 || hold1 !== 1'b0) begin n_errors++; $display("FAIL rh_en_state: got idle=%b hold=%b want 1/0", idle1, hold1); end
        n_checks++; if (idle4 !== 1'b1 || hold4 !== 1'b0) begin n_errors++; $display("FAIL rh_en_state_r4: got idle=%b hold=%b want 1/0", idle4, hold4); end
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (val4 !== 1'b0 || dig4 !== IV256_D) begin n_errors++; $display("FAIL rh_en_noop: got valid=%b digest=%h want 0/%h", val4, dig4, IV256_D); end

        // rst_ni mid-block, after selecting SHA-224 where available
        do_rst_hash(1'b1);
        start_block(ABC_BLK);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++; if (idle1 !== 1'b1 || hold1 !== 1'b0) begin n_errors++; $display("FAIL rstn_state: got idle=%b hold=%b want 1/0", idle1, hold1); end
        n_checks++; if (val1 !== 1'b0) begin n_errors++; $display("FAIL rstn_valid: got %b want 0", val1); end
        n_checks++; if (dig1 !== IV256_D) begin n_errors++; $display("FAIL rstn_digest: got %h want %h", dig1, IV256_D); end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_two_block();
        test_sha224();
        test_empty_enable_pulse();
        test_block_stable();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
